// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: registers the EX bundle, owns the data memory, produces the WB bundle
// After reset a CLEAR pass zero-fills the memory before RUN starts accepting ops.
module mem_access_stage #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64,
   parameter int DEPTH  = 256,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W+DATA_W+6:0] EX_output,
   input  logic                     flush,
   output logic [DATA_W+4:0]        WB_output,
   output logic                     init_done,
   output logic [CNT_W-1:0]         store_count,
   input  logic [ADDR_W-1:0]        dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [DATA_W+4:0]   wb_q, wb_d;
   logic                init_done_q, init_done_d;
   logic [CNT_W-1:0]    store_count_q, store_count_d;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;

   logic [ADDR_W-1:0]   ex_addr;
   logic [DATA_W-1:0]   ex_value;
   logic                ex_is_write;
   logic                ex_is_mem_write;
   logic                ex_is_load;
   logic [3:0]          ex_reg;
   logic [DATA_W-1:0]   rd_data;

   assign ex_addr         = EX_output[ADDR_W-1:0];
   assign ex_value        = EX_output[ADDR_W+DATA_W-1:ADDR_W];
   assign ex_is_write     = EX_output[ADDR_W+DATA_W];
   assign ex_is_mem_write = EX_output[ADDR_W+DATA_W+1];
   assign ex_is_load      = EX_output[ADDR_W+DATA_W+2];
   assign ex_reg          = EX_output[ADDR_W+DATA_W+6:ADDR_W+DATA_W+3];

   // Pre-edge contents, so a load sees the memory as it was before this cycle's write.
   assign rd_data  = mem[ex_addr];
   assign dbg_data = mem[dbg_addr];

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_CLEAR;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == S_CLEAR && ptr_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
   end

   always_comb begin
      mem_we        = 1'b0;
      mem_waddr     = ptr_q;
      mem_wdata     = '0;
      ptr_d         = ptr_q;
      wb_d          = '0;
      init_done_d   = init_done_q;
      store_count_d = store_count_q;
      if (state_q == S_CLEAR) begin
         mem_we = 1'b1;
         ptr_d  = ptr_q + ADDR_W'(1);
         if (ptr_q == ADDR_W'(DEPTH - 1)) init_done_d = 1'b1;
      end else if (!flush) begin
         if (ex_is_mem_write) begin
            // Store wins over load when both flags are set; never writes back.
            mem_we    = 1'b1;
            mem_waddr = ex_addr;
            mem_wdata = ex_value;
            wb_d      = {1'b0, ex_reg, ex_value};
            if (store_count_q != {CNT_W{1'b1}}) store_count_d = store_count_q + CNT_W'(1);
         end else if (ex_is_load) begin
            wb_d = {ex_is_write, ex_reg, rd_data};
         end else begin
            wb_d = {ex_is_write, ex_reg, ex_value};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= '0;
         wb_q          <= '0;
         init_done_q   <= 1'b0;
         store_count_q <= '0;
      end else begin
         ptr_q         <= ptr_d;
         wb_q          <= wb_d;
         init_done_q   <= init_done_d;
         store_count_q <= store_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
   end

   assign WB_output   = wb_q;
   assign init_done   = init_done_q;
   assign store_count = store_count_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [78:0] EX_output;
   logic        flush;
   logic [68:0] WB_output;
   logic        init_done;
   logic [15:0] store_count;
   logic [7:0]  dbg_addr;
   logic [63:0] dbg_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [68:0] exp;
      logic [68:0] mask;
   } wb_exp_t;

   wb_exp_t     sb_q[$];
   logic [63:0] model_mem [256];
   int          model_count;

   mem_access_stage dut (
      .clk(clk), .reset(reset), .EX_output(EX_output), .flush(flush),
      .WB_output(WB_output), .init_done(init_done), .store_count(store_count),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [78:0] mk_ex(input logic [3:0] rg, input logic ld, input logic mw,
                                         input logic wr, input logic [63:0] val, input logic [7:0] a);
      return {rg, ld, mw, wr, val, a};
   endfunction

   task automatic dbg_chk(input string tag, input logic [7:0] a, input logic [63:0] exp);
      dbg_addr = a;
      #1;
      chk(tag, {5'd0, dbg_data}, {5'd0, exp});
   endtask

   // Drive one RUN op, predict its WB bundle from the model, compare one edge later.
   task automatic run_op(input string tag, input logic [78:0] ex, input logic fl);
      wb_exp_t     e;
      logic [7:0]  a;
      logic [63:0] v;
      a = ex[7:0];
      v = ex[71:8];
      e.mask = '1;
      if (fl) begin
         e.exp = '0;
      end else if (ex[73]) begin
         e.exp  = 69'd0;
         e.mask = 69'd1 << 68;
         model_mem[a] = v;
         if (model_count < 65535) model_count++;
      end else if (ex[74]) begin
         e.exp = {ex[72], ex[78:75], model_mem[a]};
      end else begin
         e.exp = {ex[72], ex[78:75], v};
      end
      EX_output = ex;
      flush     = fl;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 69'd1, 69'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_wb"}, WB_output & e.mask, e.exp & e.mask);
      end
      chk({tag, "_cnt"}, {53'd0, store_count}, 69'(model_count));
      EX_output = '0;
      flush     = 1'b0;
   endtask

   // Releases reset and walks the clear pass, optionally offering stores that must be ignored.
   task automatic clear_pass(input string tag);
      reset = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         EX_output = mk_ex(4'd2, 1'b0, 1'b1, 1'b1, 64'h1234, 8'h50);
         @(posedge clk);
         #1;
         if (k == 128) chk({tag, "_wb_mid"}, WB_output, 69'd0);
         if (k == 255) chk({tag, "_init_255"}, {68'd0, init_done}, 69'd0);
         if (k == 256) chk({tag, "_init_256"}, {68'd0, init_done}, 69'd1);
      end
      EX_output = '0;
      chk({tag, "_wb_end"}, WB_output, 69'd0);
      chk({tag, "_cnt"}, {53'd0, store_count}, 69'd0);
   endtask

   initial begin
      logic [78:0] ex;
      logic [7:0]  ra;
      for (int i = 0; i < 256; i++) model_mem[i] = '0;
      model_count = 0;
      reset = 1'b1;
      EX_output = '0;
      flush = 1'b0;
      dbg_addr = '0;
      @(posedge clk);
      #1;
      chk("rst_wb", WB_output, 69'd0);
      chk("rst_init", {68'd0, init_done}, 69'd0);
      chk("rst_cnt", {53'd0, store_count}, 69'd0);

      clear_pass("clr");
      dbg_chk("dbg_00", 8'h00, 64'd0);
      dbg_chk("dbg_7f", 8'h7F, 64'd0);
      dbg_chk("dbg_ff", 8'hFF, 64'd0);
      dbg_chk("dbg_50", 8'h50, 64'd0);

      run_op("st10", mk_ex(4'd3, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF, 8'h10), 1'b0);
      dbg_chk("dbg_10", 8'h10, 64'hDEADBEEF);
      run_op("st20", mk_ex(4'd1, 1'b0, 1'b1, 1'b0, 64'd5, 8'h20), 1'b0);
      run_op("ld20", mk_ex(4'd4, 1'b1, 1'b0, 1'b1, 64'd0, 8'h20), 1'b0);
      run_op("alu", mk_ex(4'd7, 1'b0, 1'b0, 1'b1, 64'd42, 8'h00), 1'b0);
      run_op("alu_fl", mk_ex(4'd7, 1'b0, 1'b0, 1'b1, 64'd42, 8'h00), 1'b1);
      run_op("st30_fl", mk_ex(4'd2, 1'b0, 1'b1, 1'b1, 64'd9, 8'h30), 1'b1);
      dbg_chk("dbg_30", 8'h30, 64'd0);
      run_op("ldst60", mk_ex(4'd5, 1'b1, 1'b1, 1'b1, 64'd11, 8'h60), 1'b0);
      run_op("ld60", mk_ex(4'd6, 1'b1, 1'b0, 1'b1, 64'd0, 8'h60), 1'b0);
      run_op("ld70", mk_ex(4'd8, 1'b1, 1'b0, 1'b0, 64'hFFFF, 8'h70), 1'b0);
      run_op("ld10_fl", mk_ex(4'd9, 1'b1, 1'b0, 1'b1, 64'd0, 8'h10), 1'b1);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom_range(0, 7)) + 8'h80;
         ex = mk_ex(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    {$urandom, $urandom}, ra);
         run_op("rnd", ex, ($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 8; i++) dbg_chk("dbg_rnd", 8'h80 + 8'(i), model_mem[8'h80 + 8'(i)]);

      run_op("st40", mk_ex(4'd1, 1'b0, 1'b1, 1'b0, 64'd7, 8'h40), 1'b0);
      dbg_chk("dbg_40_pre", 8'h40, 64'd7);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 100; k++) @(posedge clk);
      #1;
      chk("mid_init", {68'd0, init_done}, 69'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_pass("rclr");
      dbg_chk("dbg_40_post", 8'h40, 64'd0);
      dbg_chk("dbg_10_post", 8'h10, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
